regfile_sb: RTL and testbench

Parametrised multi-read-port register file with a per-register pending-write scoreboard, for the pipelined core that follows the single-cycle datapath. Supports NUM_RD combinational read ports, one write port and an x0 hard-wired to zero. A per-register busy bit is set when an instruction claims a destination at issue and cleared at writeback, so decode can detect RAW hazards. Optional write-to-read bypass.

---
 rtl/regfile_sb.sv | 75 +++++++
 tb/tb_regfile_sb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Multi-read-port register file with x0 hard-wired to zero and a per-register
// pending-write scoreboard. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_sb #(
    parameter int unsigned REG_WIDTH = 32,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned NUM_RD    = 2,
    localparam int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_RD*AW-1:0]        rs_addr,
    output logic [NUM_RD*REG_WIDTH-1:0] rs_dout,
    output logic [NUM_RD-1:0]           rs_busy,
    input  logic                        wr_en,
    input  logic [AW-1:0]               wr_addr,
    input  logic [REG_WIDTH-1:0]        wr_din,
    input  logic                        claim_en,
    input  logic [AW-1:0]               claim_addr,
    input  logic                        flush,
    output logic                        any_busy
);

    logic [REG_WIDTH-1:0] mem_q [NUM_REGS];
    logic [REG_WIDTH-1:0] mem_d [NUM_REGS];
    logic [NUM_REGS-1:0]  busy_q;
    logic [NUM_REGS-1:0]  busy_d;
    logic                 wr_ok;

    assign wr_ok = wr_en && (wr_addr != '0);

    // Claim is applied after the write so a same-edge claim of the written register stays busy;
    // flush overrides both.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (wr_ok) begin
            mem_d[wr_addr]  = wr_din;
            busy_d[wr_addr] = 1'b0;
        end
        if (claim_en && (claim_addr != '0)) begin
            busy_d[claim_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q  <= '{default: '0};
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    assign any_busy = |busy_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0] rd_addr;
        logic          fwd;

        assign rd_addr = rs_addr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        assign fwd = wr_ok && (wr_addr == rd_addr);
`else
        assign fwd = 1'b0;
`endif
        assign rs_dout[i*REG_WIDTH +: REG_WIDTH] = fwd ? wr_din :
                                                   (rd_addr == '0) ? '0 : mem_q[rd_addr];
        assign rs_busy[i] = fwd ? 1'b0 : busy_q[rd_addr];
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb (16 x 64-bit, 4 read ports): directed scenarios then random traffic,
// each checked against an array-based reference model.
module tb_regfile_sb;

    localparam int W  = 64;
    localparam int N  = 16;
    localparam int R  = 4;
    localparam int AW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [R*AW-1:0]   rs_addr;
    logic [R*W-1:0]    rs_dout;
    logic [R-1:0]      rs_busy;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [W-1:0]      wr_din;
    logic              claim_en;
    logic [AW-1:0]     claim_addr;
    logic              flush;
    logic              any_busy;

    regfile_sb #(
        .REG_WIDTH(W),
        .NUM_REGS (N),
        .NUM_RD   (R)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rs_addr   (rs_addr),
        .rs_dout   (rs_dout),
        .rs_busy   (rs_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_din    (wr_din),
        .claim_en  (claim_en),
        .claim_addr(claim_addr),
        .flush     (flush),
        .any_busy  (any_busy)
    );

    always #5 clk = ~clk;

    logic [W-1:0] m_mem  [N];
    bit           m_busy [N];
    int           total  = 0;
    int           passes = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    function automatic bit wr_hits(input int a);
`ifdef REGFILE_BYPASS_EN
        return wr_en && (wr_addr != 0) && (int'(wr_addr) == a);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_all(input string tag);
        bit exp_any;
        int a;
        logic [W-1:0] exp_d;
        bit exp_b;
        #1;
        exp_any = 1'b0;
        for (int i = 0; i < N; i++) exp_any |= m_busy[i];
        for (int p = 0; p < R; p++) begin
            a = int'(rs_addr[p*AW +: AW]);
            if (a == 0) begin
                exp_d = '0;
                exp_b = 1'b0;
            end else if (wr_hits(a)) begin
                exp_d = wr_din;
                exp_b = 1'b0;
            end else begin
                exp_d = m_mem[a];
                exp_b = m_busy[a];
            end
            chk($sformatf("%s.dout%0d", tag, p), rs_dout[p*W +: W], exp_d);
            chk($sformatf("%s.busy%0d", tag, p), {63'b0, rs_busy[p]}, {63'b0, exp_b});
        end
        chk($sformatf("%s.any_busy", tag), {63'b0, any_busy}, {63'b0, exp_any});
    endtask

    // Model update follows the rules directly: write clears, later claim sets, flush wins.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_mem[wr_addr]  = wr_din;
                m_busy[wr_addr] = 1'b0;
            end
            if (claim_en && claim_addr != 0) m_busy[claim_addr] = 1'b1;
            if (flush) for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
        end
        #1;
    endtask

    task automatic step(input string tag);
        check_all(tag);
        tick();
    endtask

    task automatic idle();
        wr_en = 0; wr_addr = 0; wr_din = '0;
        claim_en = 0; claim_addr = 0; flush = 0;
    endtask

    task automatic rd(input int a0, input int a1, input int a2, input int a3);
        rs_addr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rd(0, 1, 2, 3);
        model_reset();
        tick();
        step("reset");
        rst = 1'b0;

        // Async reset between edges discards stored data and busy bits
        wr_en = 1; wr_addr = 5; wr_din = 64'hDEADBEEF;
        claim_en = 1; claim_addr = 6;
        rd(5, 6, 5, 0);
        step("pre_rst_wr");
        idle();
        step("pre_rst_rd");
        #2;
        rst = 1'b1;
        model_reset();
        check_all("async_rst");
        wr_en = 1; wr_addr = 5; wr_din = 64'h1111; claim_en = 1; claim_addr = 5;
        tick();
        step("rst_held");
        rst = 1'b0;
        idle();
        step("post_rst");

        // x0 ignores writes and claims
        wr_en = 1; wr_addr = 0; wr_din = '1; claim_en = 1; claim_addr = 0;
        rd(0, 0, 0, 0);
        step("x0_drive");
        idle();
        step("x0_read");

        // Write then read on all ports
        wr_en = 1; wr_addr = 7; wr_din = 64'h12345678;
        rd(7, 7, 7, 7);
        step("wr7_same");
        idle();
        step("wr7_next");

        // Scoreboard claim then writeback
        claim_en = 1; claim_addr = 3;
        rd(3, 3, 0, 7);
        step("claim3");
        idle();
        step("busy3_a");
        step("busy3_b");
        wr_en = 1; wr_addr = 3; wr_din = 64'hA5;
        step("wb3");
        idle();
        step("after_wb3");

        // Same-edge claim and write, then flush overriding a claim
        wr_en = 1; wr_addr = 9; wr_din = 64'hCAFE; claim_en = 1; claim_addr = 9;
        rd(9, 10, 9, 10);
        step("collide9");
        idle();
        flush = 1; claim_en = 1; claim_addr = 10;
        step("flush");
        idle();
        step("after_flush");

        // Four ports, boundary registers, independent busy bits
        wr_en = 1; wr_addr = 1; wr_din = 64'h0123456789ABCDEF;
        step("wr1");
        wr_addr = 15; wr_din = 64'hFEDCBA9876543210; claim_en = 1; claim_addr = 1;
        step("wr15");
        idle();
        claim_en = 1; claim_addr = 1;
        rd(1, 15, 0, 1);
        step("reclaim1");
        idle();
        step("ports4");

        for (int c = 0; c < 400; c++) begin
            wr_en      = ($urandom_range(0, 2) != 0);
            wr_addr    = AW'($urandom);
            wr_din     = {$urandom, $urandom};
            claim_en   = ($urandom_range(0, 1) != 0);
            claim_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
            flush      = ($urandom_range(0, 15) == 0);
            rs_addr    = ($urandom_range(0, 3) == 0) ? {R{wr_addr}} : (R*AW)'($urandom);
            step("rand");
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
